// File: rtl/bob_uart_pkg.sv
// -----------------------------------------------------------------------------
// bob_uart_pkg
// Shared types and constants for the BOB UART blocks (transmitter now, receiver
// later).
//
// Contents:
//   DATA_BITS     : width of one data word (9 bits)
//   PARITY_BITS   : 1 when the parity bit is built in, 0 otherwise
//   LINE_START    : serial level during the start bit
//   LINE_STOP     : serial level during stop bits
//   LINE_IDLE     : serial level while nothing is being sent
//   tx_state_e    : transmitter FSM states
//   frame_cycles(): clock cycles taken by one complete frame
//
// Configuration macro: BOB_UART_PARITY_EN
//   When defined, an even-parity bit follows the data bits and the PARITY
//   state exists. When undefined, the frame has no parity bit.
// -----------------------------------------------------------------------------
package bob_uart_pkg;

    localparam int DATA_BITS = 9;

`ifdef BOB_UART_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;
    localparam logic LINE_IDLE  = 1'b1;

    // Explicit encodings so the state values stay the same whether or not
    // the PARITY state is built in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef BOB_UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_e;

    // Number of clock cycles from the first start-bit cycle to the end of
    // the last stop-bit cycle.
    function automatic int frame_cycles(input int clks_per_bit, input int stop_bits);
        return (1 + DATA_BITS + PARITY_BITS + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/bob_baud_tick.sv
// -----------------------------------------------------------------------------
// bob_baud_tick
// Bit-time counter used by the UART. It counts 0..CLKS_PER_BIT-1 while
// enabled and wraps to 0. It emits a one-cycle tick on the terminal count,
// which marks the last clock of a bit time. The receiver will reuse this
// block.
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (2..65535)
//
// Ports:
//   clock  in  : rising-edge clock
//   reset  in  : asynchronous active-high reset; clears the counter
//   enable in  : count while high
//   clear  in  : restart the bit time at 0; has priority over enable
//   tick   out : high during the last cycle of each bit time
// -----------------------------------------------------------------------------
module bob_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the values from before the clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == TERMINAL) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign tick = enable && !clear && (count == TERMINAL);

endmodule

// File: rtl/bob_uart_tx.sv
// -----------------------------------------------------------------------------
// bob_uart_tx
// UART transmitter for 9-bit reply words. The frame is: one start bit (low),
// then 9 data bits sent LSB first, then an optional even-parity bit, then
// STOP_BITS stop bits (high). Every bit lasts CLKS_PER_BIT clocks. The serial
// line comes straight from a flop and changes only on bit-time boundaries.
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per bit (2..65535)
//   STOP_BITS    : stop bits per frame (1 or 2)
//
// Ports:
//   clock     in  : rising-edge clock
//   reset     in  : asynchronous active-high reset; aborts any frame
//   tx_data   in  : [8:0] word to send, captured only when accepted
//   tx_send   in  : request to send; accepted when tx_ready is high
//   tx_ready  out : high only in IDLE
//   tx_serial out : serial line, idles high
//   tx_busy   out : high from acceptance to the end of the last stop bit
//
// Configuration macro: BOB_UART_PARITY_EN (even parity over the 9 data bits)
// -----------------------------------------------------------------------------
module bob_uart_tx
    import bob_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_send,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy
);

    localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP_IDX = 4'(STOP_BITS - 1);

    tx_state_e            state, state_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic [3:0]           bit_idx, bit_idx_next;
    logic                 serial_q, serial_next;
    logic                 accept;
    logic                 bit_tick;
`ifdef BOB_UART_PARITY_EN
    logic                 parity_q, parity_next;
`endif

    assign tx_ready  = (state == ST_IDLE);
    assign tx_busy   = (state != ST_IDLE);
    assign tx_serial = serial_q;
    assign accept    = tx_send && tx_ready;

    // The bit time restarts on acceptance, so the start bit is a full
    // CLKS_PER_BIT long. The counter is idle outside a frame.
    bob_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clock (clock),
        .reset (reset),
        .enable(tx_busy),
        .clear (accept),
        .tick  (bit_tick)
    );

    // Next-state logic. serial_next is the level for the bit that starts
    // after the current edge, so the line flop changes exactly on bit
    // boundaries.
    always_comb begin
        // NOTE: every output of this block gets a default first. Without it, a
        // path that skips an assignment would infer a latch.
        state_next   = state;
        shreg_next   = shreg;
        bit_idx_next = bit_idx;
        serial_next  = serial_q;
`ifdef BOB_UART_PARITY_EN
        parity_next  = parity_q;
`endif

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next  = ST_START;
                    shreg_next  = tx_data;
                    serial_next = LINE_START;
`ifdef BOB_UART_PARITY_EN
                    parity_next = ^tx_data;
`endif
                end
            end

            ST_START: begin
                if (bit_tick) begin
                    state_next   = ST_DATA;
                    bit_idx_next = '0;
                    serial_next  = shreg[0];
                end
            end

            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_idx == LAST_DATA_IDX) begin
                        bit_idx_next = '0;
`ifdef BOB_UART_PARITY_EN
                        state_next   = ST_PARITY;
                        serial_next  = parity_q;
`else
                        state_next   = ST_STOP;
                        serial_next  = LINE_STOP;
`endif
                    end else begin
                        // After the shift, shreg[0] again holds the bit now
                        // on the line.
                        shreg_next   = shreg >> 1;
                        serial_next  = shreg[1];
                        bit_idx_next = bit_idx + 4'd1;
                    end
                end
            end

`ifdef BOB_UART_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    state_next   = ST_STOP;
                    bit_idx_next = '0;
                    serial_next  = LINE_STOP;
                end
            end
`endif

            ST_STOP: begin
                // bit_idx counts the stop bits sent so far.
                if (bit_tick) begin
                    if (bit_idx == LAST_STOP_IDX) begin
                        state_next   = ST_IDLE;
                        bit_idx_next = '0;
                    end else begin
                        bit_idx_next = bit_idx + 4'd1;
                    end
                    serial_next = LINE_STOP;
                end
            end

            default: begin
                state_next   = ST_IDLE;
                bit_idx_next = '0;
                serial_next  = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            serial_q <= LINE_IDLE;
`ifdef BOB_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            bit_idx  <= bit_idx_next;
            serial_q <= serial_next;
`ifdef BOB_UART_PARITY_EN
            parity_q <= parity_next;
`endif
        end
    end

endmodule

// File: tb/tb_bob_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_bob_uart_tx
// Self-checking bench for bob_uart_tx. It uses two instances:
//   dut0 : CLKS_PER_BIT=4, STOP_BITS=1
//   dut1 : CLKS_PER_BIT=2, STOP_BITS=2
// The expected line levels for each frame come from a list of bit levels
// (start, data LSB first, optional parity, stop bits). Each level is held for
// CLKS_PER_BIT cycles. Outputs are sampled on the falling clock edge.
// Honours BOB_UART_PARITY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_bob_uart_tx;

    localparam int N0 = 4;
    localparam int S0 = 1;
    localparam int N1 = 2;
    localparam int S1 = 2;

    logic       clock;
    logic       reset;
    logic [8:0] tx_data0, tx_data1;
    logic       tx_send0, tx_send1;
    logic       tx_ready0, tx_serial0, tx_busy0;
    logic       tx_ready1, tx_serial1, tx_busy1;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected bit levels of the frame currently being checked.
    logic exp_q[$];

    bob_uart_tx #(.CLKS_PER_BIT(N0), .STOP_BITS(S0)) dut0 (
        .clock    (clock),
        .reset    (reset),
        .tx_data  (tx_data0),
        .tx_send  (tx_send0),
        .tx_ready (tx_ready0),
        .tx_serial(tx_serial0),
        .tx_busy  (tx_busy0)
    );

    bob_uart_tx #(.CLKS_PER_BIT(N1), .STOP_BITS(S1)) dut1 (
        .clock    (clock),
        .reset    (reset),
        .tx_data  (tx_data1),
        .tx_send  (tx_send1),
        .tx_ready (tx_ready1),
        .tx_serial(tx_serial1),
        .tx_busy  (tx_busy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observed {serial, busy, ready} of one instance.
    function automatic logic [2:0] obs(input int sel);
        return (sel == 0) ? {tx_serial0, tx_busy0, tx_ready0}
                          : {tx_serial1, tx_busy1, tx_ready1};
    endfunction

    task automatic drive(input int sel, input logic send, input logic [8:0] d);
        if (sel == 0) begin
            tx_send0 = send;
            tx_data0 = d;
        end else begin
            tx_send1 = send;
            tx_data1 = d;
        end
    endtask

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed {serial,busy,ready}=%b expected=%b", tag, got, want);
    endtask

    // Reference frame: list of line levels, one entry per bit time.
    task automatic build_levels(input logic [8:0] d, input int stop_bits);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int b = 0; b < 9; b++) exp_q.push_back(d[b]);
`ifdef BOB_UART_PARITY_EN
        exp_q.push_back(^d);
`endif
        for (int s = 0; s < stop_bits; s++) exp_q.push_back(1'b1);
    endtask

    // Starts at a falling edge with the instance idle. Sends d and checks
    // every cycle of the frame. It returns at the falling edge of the first
    // cycle after the frame ends.
    //   hold   : keep tx_send high and present nxt for the next frame
    //   inject : pulse tx_send with 9'h000 in the 10th frame cycle
    task automatic run_frame(input int sel, input logic [8:0] d, input bit hold,
                             input logic [8:0] nxt, input bit inject);
        int n;
        int f;
        n = (sel == 0) ? N0 : N1;
        build_levels(d, (sel == 0) ? S0 : S1);
        f = exp_q.size() * n;
        check($sformatf("idle_before_dut%0d_%03h", sel, d), obs(sel), 3'b101);
        drive(sel, 1'b1, d);
        @(negedge clock);
        drive(sel, hold, hold ? nxt : 9'($urandom));
        for (int i = 0; i < f; i++) begin
            check($sformatf("frame_dut%0d_%03h_cyc%0d", sel, d, i), obs(sel),
                  {exp_q[i / n], 2'b10});
            if (inject && i == 9) drive(sel, 1'b1, 9'h000);
            else if (!hold) drive(sel, 1'b0, 9'($urandom));
            @(negedge clock);
        end
    endtask

    initial begin
        logic [8:0] d;

        reset = 1'b1;
        drive(0, 1'b0, 9'h000);
        drive(1, 1'b0, 9'h000);

        // While reset is held, both instances idle and requests are ignored.
        @(negedge clock);
        check("reset_dut0", obs(0), 3'b101);
        check("reset_dut1", obs(1), 3'b101);
        drive(0, 1'b1, 9'h1A5);
        @(negedge clock);
        check("reset_send_ignored", obs(0), 3'b101);
        drive(0, 1'b0, 9'h000);

        // Release reset. The first edge after release accepts a word.
        reset = 1'b0;
        run_frame(0, 9'h1A5, 1'b0, 9'h000, 1'b0);

        // A request in the middle of a frame is ignored, and no second frame
        // follows.
        run_frame(0, 9'h1A5, 1'b0, 9'h000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("no_extra_frame_%0d", k), obs(0), 3'b101);
            @(negedge clock);
        end

        // Random words. tx_data is scrambled during each frame.
        for (int k = 0; k < 4; k++) begin
            d = 9'($urandom);
            run_frame(0, d, 1'b0, 9'h000, 1'b0);
        end

        // tx_send held high with alternating words: one idle cycle between
        // frames.
        run_frame(0, 9'h155, 1'b1, 9'h0AA, 1'b0);
        run_frame(0, 9'h0AA, 1'b1, 9'h155, 1'b0);
        run_frame(0, 9'h155, 1'b0, 9'h000, 1'b0);

        // Reset asserted during data bit 4 (bit 4 of 9'h0EF is 0).
        d = 9'h0EF;
        build_levels(d, S0);
        drive(0, 1'b1, d);
        @(negedge clock);
        drive(0, 1'b0, 9'h000);
        for (int i = 0; i < 5 * N0 + 2; i++) begin
            check($sformatf("pre_reset_cyc%0d", i), obs(0), {exp_q[i / N0], 2'b10});
            @(negedge clock);
        end
        check("data_bit4_low", obs(0), 3'b010);
        #2 reset = 1'b1;
        #1 check("reset_async_dut0", obs(0), 3'b101);
        check("reset_async_dut1", obs(1), 3'b101);
        @(negedge clock);
        check("reset_held_dut0", obs(0), 3'b101);
        reset = 1'b0;
        run_frame(0, 9'h1FF, 1'b0, 9'h000, 1'b0);
        check("after_1ff_idle", obs(0), 3'b101);

        // Two stop bits, two clocks per bit.
        run_frame(1, 9'h1A5, 1'b0, 9'h000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            d = 9'($urandom);
            run_frame(1, d, 1'b0, 9'h000, 1'b0);
        end
        check("dut1_final_idle", obs(1), 3'b101);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
